mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand/result width, signed fixed point.
REQ-003 SHALL have parameter FRAC_BITS, default 10, fractional bits of operands and result.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot grant; at most one bit high per cycle.
REQ-008 SHALL have port req_a  input  NUM_REQ*DATA_WIDTH  packed operand A, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_b  input  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse marking the result owner.
REQ-011 SHALL have port rsp_data  output  DATA_WIDTH  product in the same Q format as the operands.
REQ-012 SHALL have port rsp_overflow  output  1  result was clamped; qualified by any rsp_valid bit.

Function
REQ-013 SHALL accept a request from requester i in cycle k when req_valid[i] and req_ready[i] are both high.
REQ-014 SHALL drive req_ready combinationally from req_valid and the round-robin pointer: first valid index at or after the pointer, wrapping modulo NUM_REQ.
REQ-015 SHALL advance the pointer to (granted index + 1) mod NUM_REQ on each accept; no accept leaves the pointer unchanged.
REQ-016 SHALL sustain one accept per cycle with no bubbles under continuous requests.
REQ-017 SHALL run a 3-stage pipeline: S1 registers operands and owner index; S2 registers the full 2*DATA_WIDTH signed product; S3 registers the scaled result.
REQ-018 SHALL assert rsp_valid[i] in exactly cycle k+3 for an accept in cycle k, for one cycle, with rsp_data and rsp_overflow valid in that cycle.
REQ-019 SHALL compute the result as the signed product arithmetically shifted right by FRAC_BITS (truncation toward minus infinity, no rounding).
REQ-020 SHALL deliver results in accept order; there is no response backpressure and requesters must take the result when rsp_valid is high.
REQ-021 SHALL hold rsp_data and rsp_overflow at zero in cycles with no rsp_valid bit set.
REQ-022 SHALL hold req_ready at all zeros while reset is high.

Reset
REQ-023 SHALL, on reset, clear all pipeline valid bits, rsp_valid, rsp_data and rsp_overflow to 0 and set the pointer to 0.
REQ-024 SHALL discard transactions in flight when reset is asserted mid-operation; no rsp_valid for them is ever produced.

Configuration
REQ-025 SHALL, with macro MUL_ARBITER_SAT_EN defined, clamp a shifted product outside the signed DATA_WIDTH range to 0x7FFFFFFF or 0x80000000 (for DATA_WIDTH 32) and set rsp_overflow to 1.
REQ-026 SHALL, without MUL_ARBITER_SAT_EN, output the low DATA_WIDTH bits of the shifted product and tie rsp_overflow to 0.

Structure
REQ-027 SHALL take DATA_WIDTH and FRAC_BITS default constants, the signed fixed-point typedef fxp_t, and the pipeline-stage struct (valid, owner index, payload) from shared package mul_arbiter_pkg.
REQ-028 SHALL place the round-robin grant logic and pointer register in sub-module mul_arbiter_rr.

Verification
REQ-029 SHALL cover a single request: requester 0, a=0x00000800 (2.0), b=0x00000C00 (3.0) in cycle k -> rsp_valid=0001 in k+3, rsp_data=0x00001800, rsp_overflow=0.
REQ-030 SHALL cover all four requesters valid continuously from reset -> grants 0,1,2,3,0 on consecutive cycles, with one response per cycle in that order.
REQ-031 SHALL cover a signed operand: a=0xFFFFFC00 (-1.0), b=0x00000600 (1.5) -> rsp_data=0xFFFFFA00.
REQ-032 SHALL cover overflow: a=b=0x7FFFFFFF -> with SAT_EN rsp_data=0x7FFFFFFF and rsp_overflow=1; without it rsp_data=0xFFC00000 and rsp_overflow=0.
REQ-033 SHALL cover pointer wrap: pointer at 2 with only requesters 1 and 3 valid -> grant 3, then 1 next cycle, pointer ends at 2.
REQ-034 SHALL cover reset mid-flight: accept from requester 1, reset high the next cycle -> no rsp_valid ever appears and the next grant starts from index 0.

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// Shared constants and types for the round-robin arbitrated fixed-point multiplier.
// Build option: MUL_ARBITER_SAT_EN enables result saturation (see mul_arbiter.sv).
package mul_arbiter_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned FRAC_BITS_DEF  = 10;
    localparam int unsigned IDX_W          = 3;

    typedef logic signed [DATA_WIDTH_DEF-1:0] fxp_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] owner;
        fxp_t             payload;
    } stage_t;

endpackage

// File: rtl/mul_arbiter_rr.sv
// Round-robin grant: first valid requester at or after the pointer, with pointer register.
module mul_arbiter_rr
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               accept
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        accept    = 1'b0;
        idx       = '0;
        if (!reset) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
                if (!accept && valid[idx]) begin
                    accept     = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = IDX_W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= PTR_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// NUM_REQ requesters share one 3-stage signed fixed-point multiplier, results in accept order.
// Define MUL_ARBITER_SAT_EN to clamp out-of-range results and report rsp_overflow.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_overflow
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic [IDX_W-1:0] grant_idx;
    logic             accept;

    logic                         s1_valid;
    logic [IDX_W-1:0]             s1_owner;
    logic signed [DATA_WIDTH-1:0] s1_a;
    logic signed [DATA_WIDTH-1:0] s1_b;

    logic                     s2_valid;
    logic [IDX_W-1:0]         s2_owner;
    logic signed [PROD_W-1:0] s2_prod;

    logic signed [PROD_W-1:0] shifted;
    logic [DATA_WIDTH-1:0]    scaled;
    logic                     ovf;

    stage_t s3;
    logic   s3_ovf;

    mul_arbiter_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .accept    (accept)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_owner <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_owner <= '0;
            s2_prod  <= '0;
        end else begin
            s1_valid <= accept;
            s1_owner <= grant_idx;
            s1_a     <= req_a[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            s1_b     <= req_b[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            s2_prod  <= s1_a * s1_b;
        end
    end

    // Q-format rescale; floor division by 2^FRAC_BITS via arithmetic shift
    always_comb begin
        shifted = s2_prod >>> FRAC_BITS;
        scaled  = shifted[DATA_WIDTH-1:0];
        ovf     = 1'b0;
`ifdef MUL_ARBITER_SAT_EN
        if (!((&shifted[PROD_W-1:DATA_WIDTH-1]) || !(|shifted[PROD_W-1:DATA_WIDTH-1]))) begin
            ovf    = 1'b1;
            scaled = shifted[PROD_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
    end

`ifndef MUL_ARBITER_SAT_EN
    logic unused_high_bits;
    assign unused_high_bits = ^shifted[PROD_W-1:DATA_WIDTH];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            s3     <= '0;
            s3_ovf <= 1'b0;
        end else if (s2_valid) begin
            s3.valid   <= 1'b1;
            s3.owner   <= s2_owner;
            s3.payload <= fxp_t'(scaled);
            s3_ovf     <= ovf;
        end else begin
            s3     <= '0;
            s3_ovf <= 1'b0;
        end
    end

    assign rsp_valid    = s3.valid ? (NUM_REQ'(1) << s3.owner) : '0;
    assign rsp_data     = s3.payload[DATA_WIDTH-1:0];
    assign rsp_overflow = s3_ovf;

endmodule
